// File: rtl/lcd_spi_rx.sv
// Serial LCD-style line receiver: MODE/ADDR/DATA/DUMMY framing, valid/ready word output.
// Optional 16-bit line counter output enabled with LCD_SPI_RX_LINECOUNT_EN.
module lcd_spi_rx #(
  parameter int LINE_BITS = 336,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16
) (
  input  logic              clk12,
  input  logic              reset_n,
  input  logic              lcd_sclk,
  input  logic              lcd_si,
  input  logic              lcd_scs,
  output logic [ADDR_W-1:0] line_addr,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              line_done,
  output logic              frame_done,
  output logic              clear_req,
  output logic              err_trunc,
  output logic              err_ovf
`ifdef LCD_SPI_RX_LINECOUNT_EN
  ,
  output logic [15:0]       line_count
`endif
);

  localparam int MAX_A = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int SH_W  = (MAX_A > 8) ? MAX_A : 8;
  localparam int MAX_C = (LINE_BITS > SH_W) ? LINE_BITS : SH_W;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam int WC_W  = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, MODE, ADDR, DATA, DUMMY, SKIP} state_t;

  state_t state, state_next;

  logic [2:0]       sclk_sync, scs_sync;
  logic [1:0]       si_sync;
  logic [1:0]       settle;
  logic             armed;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WC_W-1:0]  wcnt, wcnt_next;
  logic [SH_W-2:0]  sreg;
  logic [SH_W-1:0]  sh_next;

  logic sclk_rise, scs_s, scs_start, scs_fall, sample;
  logic word_done, addr_done, clear_hit, line_hit, frame_hit, trunc_hit;

  // Synchronizer stage: two flops per input, a third for edge detection
  always_ff @(posedge clk12) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      scs_sync  <= '0;
      si_sync   <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], lcd_sclk};
      scs_sync  <= {scs_sync[1:0], lcd_scs};
      si_sync   <= {si_sync[0], lcd_si};
    end
  end

  // A frame start is accepted only once scs has been seen low after reset,
  // so a select still asserted across reset cannot masquerade as a fresh edge.
  always_ff @(posedge clk12) begin
    if (!reset_n) begin
      settle <= '0;
      armed  <= 1'b0;
    end else if (settle != 2'd2) begin
      settle <= settle + 2'd1;
    end else if (!scs_s) begin
      armed <= 1'b1;
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign scs_s     = scs_sync[1];
  assign scs_start = scs_sync[1] & ~scs_sync[2] & armed;
  assign scs_fall  = ~scs_sync[1] & scs_sync[2];
  assign sample    = sclk_rise & scs_s;
  assign sh_next   = {sreg, si_sync[1]};

  always_ff @(posedge clk12) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wcnt_next  = wcnt;
    word_done  = 1'b0;
    addr_done  = 1'b0;
    clear_hit  = 1'b0;
    line_hit   = 1'b0;
    frame_hit  = 1'b0;
    trunc_hit  = 1'b0;
    if (scs_fall) begin
      state_next = IDLE;
      cnt_next   = '0;
      wcnt_next  = '0;
      case (state)
        MODE, ADDR: if (cnt == '0) frame_hit = 1'b1;
                    else           trunc_hit = 1'b1;
        DATA, DUMMY: trunc_hit = 1'b1;
        SKIP:        frame_hit = 1'b1;
        default: ;
      endcase
    end else begin
      case (state)
        IDLE: if (scs_start) begin
          state_next = MODE;
          cnt_next   = '0;
        end
        MODE: if (sample) begin
          if (cnt == CNT_W'(7)) begin
            cnt_next = '0;
            // Clear wins over write when both mode bits are set
            if (sh_next[5]) begin
              clear_hit  = 1'b1;
              state_next = SKIP;
            end else if (sh_next[7]) begin
              state_next = ADDR;
            end else begin
              state_next = SKIP;
            end
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        ADDR: if (sample) begin
          if (cnt == CNT_W'(ADDR_W - 1)) begin
            addr_done  = 1'b1;
            cnt_next   = '0;
            wcnt_next  = '0;
            state_next = DATA;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        DATA: if (sample) begin
          if (wcnt == WC_W'(DATA_W - 1)) begin
            word_done = 1'b1;
            wcnt_next = '0;
          end else begin
            wcnt_next = wcnt + WC_W'(1);
          end
          if (cnt == CNT_W'(LINE_BITS - 1)) begin
            cnt_next   = '0;
            state_next = DUMMY;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        DUMMY: if (sample) begin
          if (cnt == CNT_W'(7)) begin
            line_hit   = 1'b1;
            cnt_next   = '0;
            state_next = ADDR;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output stage: shift register, line address, word handshake and flags
  always_ff @(posedge clk12) begin
    if (!reset_n) begin
      cnt        <= '0;
      wcnt       <= '0;
      sreg       <= '0;
      line_addr  <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      clear_req  <= 1'b0;
      err_trunc  <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      wcnt       <= wcnt_next;
      line_done  <= line_hit;
      frame_done <= frame_hit;
      clear_req  <= clear_hit;
      if (sample)    sreg      <= sh_next[SH_W-2:0];
      if (addr_done) line_addr <= sh_next[ADDR_W-1:0];
      if (trunc_hit) err_trunc <= 1'b1;
      if (word_done) begin
        if (data_valid && !data_ready) begin
          err_ovf <= 1'b1;
        end else begin
          data       <= sh_next[DATA_W-1:0];
          data_valid <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

`ifdef LCD_SPI_RX_LINECOUNT_EN
  always_ff @(posedge clk12) begin
    if (!reset_n)      line_count <= '0;
    else if (line_hit) line_count <= line_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Directed bench for lcd_spi_rx: single/multi line, clear, backpressure, truncation, reset.
module tb_lcd_spi_rx;

  logic        clk12 = 1'b0;
  logic        reset_n = 1'b0;
  logic        lcd_sclk = 1'b0;
  logic        lcd_si = 1'b0;
  logic        lcd_scs = 1'b0;
  logic        data_ready = 1'b1;
  logic [9:0]  line_addr;
  logic [15:0] data;
  logic        data_valid, line_done, frame_done, clear_req, err_trunc, err_ovf;
`ifdef LCD_SPI_RX_LINECOUNT_EN
  logic [15:0] line_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  int n_xfer = 0, n_bad = 0, n_line = 0, n_frame = 0, n_clear = 0, n_vld = 0;
  logic [15:0] exp_word = 16'h0000;

  lcd_spi_rx dut (
    .clk12      (clk12),
    .reset_n    (reset_n),
    .lcd_sclk   (lcd_sclk),
    .lcd_si     (lcd_si),
    .lcd_scs    (lcd_scs),
    .line_addr  (line_addr),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .line_done  (line_done),
    .frame_done (frame_done),
    .clear_req  (clear_req),
    .err_trunc  (err_trunc),
    .err_ovf    (err_ovf)
`ifdef LCD_SPI_RX_LINECOUNT_EN
    ,
    .line_count (line_count)
`endif
  );

  always #5 clk12 = ~clk12;

  // Output monitor, sampled on the falling edge
  always @(negedge clk12) begin
    if (reset_n) begin
      if (data_valid) n_vld++;
      if (data_valid && data_ready) begin
        n_xfer++;
        if (data !== exp_word) n_bad++;
      end
      if (line_done)  n_line++;
      if (frame_done) n_frame++;
      if (clear_req)  n_clear++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    n_xfer = 0; n_bad = 0; n_line = 0; n_frame = 0; n_clear = 0; n_vld = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk12);
    reset_n  = 1'b0;
    lcd_scs  = 1'b0;
    lcd_sclk = 1'b0;
    lcd_si   = 1'b0;
    repeat (2) @(posedge clk12);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk12);
    #1 clear_mon();
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk12);
    lcd_si = b;
    repeat (2) @(negedge clk12);
    lcd_sclk = 1'b1;
    repeat (3) @(negedge clk12);
    lcd_sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic scs_up();
    @(negedge clk12);
    lcd_scs = 1'b1;
    repeat (4) @(negedge clk12);
  endtask

  task automatic scs_down();
    repeat (4) @(negedge clk12);
    lcd_scs = 1'b0;
    repeat (8) @(negedge clk12);
  endtask

  task automatic send_line(input logic [9:0] a, input logic [15:0] w);
    send_bits({22'd0, a}, 10);
    repeat (21) send_bits({16'd0, w}, 16);
    send_bits(32'd0, 8);
  endtask

  initial begin
    // Reset state
    apply_reset();
    @(negedge clk12);
    check("rst_data", {16'd0, data}, 32'h0);
    check("rst_valid", {31'd0, data_valid}, 32'h0);
    check("rst_addr", {22'd0, line_addr}, 32'h0);
    check("rst_flags", {26'd0, line_done, frame_done, clear_req, err_trunc, err_ovf, 1'b0}, 32'h0);

    // Single line
    exp_word = 16'hA5A5;
    scs_up();
    send_bits(32'h80, 8);
    send_line(10'h005, 16'hA5A5);
    scs_down();
    check("l1_words", n_xfer, 32'd21);
    check("l1_bad", n_bad, 32'd0);
    check("l1_addr", {22'd0, line_addr}, 32'h005);
    check("l1_line", n_line, 32'd1);
    check("l1_frame", n_frame, 32'd1);
    check("l1_errs", {30'd0, err_trunc, err_ovf}, 32'h0);
    check("l1_clear", n_clear, 32'd0);

    // Two lines
    apply_reset();
    exp_word = 16'h3C3C;
    scs_up();
    send_bits(32'h80, 8);
    send_line(10'h000, 16'h3C3C);
    send_line(10'h217, 16'h3C3C);
    scs_down();
    check("l2_words", n_xfer, 32'd42);
    check("l2_bad", n_bad, 32'd0);
    check("l2_line", n_line, 32'd2);
    check("l2_addr", {22'd0, line_addr}, 32'h217);
    check("l2_frame", n_frame, 32'd1);
`ifdef LCD_SPI_RX_LINECOUNT_EN
    check("l2_count", {16'd0, line_count}, 32'd2);
`endif

    // Clear command (mode bit 7 also set on a second clear shows priority)
    apply_reset();
    scs_up();
    send_bits(32'h20, 8);
    send_bits(32'h00, 8);
    scs_down();
    check("clr_pulse", n_clear, 32'd1);
    check("clr_vld", n_vld, 32'd0);
    check("clr_frame", n_frame, 32'd1);
    check("clr_trunc", {31'd0, err_trunc}, 32'h0);
    clear_mon();
    scs_up();
    send_bits(32'hA0, 8);
    send_bits(32'hFF, 8);
    scs_down();
    check("clr_prio", n_clear, 32'd1);
    check("clr_prio_vld", n_vld, 32'd0);

    // Backpressure
    apply_reset();
    @(posedge clk12); #1 data_ready = 1'b0;
    exp_word = 16'h1234;
    scs_up();
    send_bits(32'h80, 8);
    send_bits(32'h001, 10);
    send_bits(32'h1234, 16);
    repeat (20) send_bits(32'hFFFF, 16);
    send_bits(32'd0, 8);
    scs_down();
    check("bp_data", {16'd0, data}, 32'h1234);
    check("bp_valid", {31'd0, data_valid}, 32'h1);
    check("bp_ovf", {31'd0, err_ovf}, 32'h1);
    check("bp_line", n_line, 32'd1);
    check("bp_frame", n_frame, 32'd1);
    @(posedge clk12); #1 data_ready = 1'b1;
    repeat (4) @(posedge clk12);
    #1;
    check("bp_xfer", n_xfer, 32'd1);
    check("bp_bad", n_bad, 32'd0);
    check("bp_drained", {31'd0, data_valid}, 32'h0);
    check("bp_ovf_sticky", {31'd0, err_ovf}, 32'h1);

    // Truncation after 100 data bits
    apply_reset();
    exp_word = 16'hA5A5;
    scs_up();
    send_bits(32'h80, 8);
    send_bits(32'h003, 10);
    repeat (6) send_bits(32'hA5A5, 16);
    send_bits(32'hA, 4);
    scs_down();
    check("tr_words", n_xfer, 32'd6);
    check("tr_bad", n_bad, 32'd0);
    check("tr_trunc", {31'd0, err_trunc}, 32'h1);
    check("tr_frame", n_frame, 32'd0);
    check("tr_line", n_line, 32'd0);
    check("tr_idle", {29'd0, dut.state}, 32'd0);

    // Reset in the middle of DATA, then a full frame
    apply_reset();
    exp_word = 16'h5555;
    scs_up();
    send_bits(32'h80, 8);
    send_bits(32'h007, 10);
    send_bits(32'h5555, 16);
    send_bits(32'h5555, 16);
    send_bits(32'h55, 8);
    @(negedge clk12);
    reset_n = 1'b0;
    @(negedge clk12);
    reset_n = 1'b1;
    check("mr_data", {16'd0, data}, 32'h0);
    check("mr_valid", {31'd0, data_valid}, 32'h0);
    check("mr_addr", {22'd0, line_addr}, 32'h0);
    check("mr_flags", {27'd0, line_done, frame_done, clear_req, err_trunc, err_ovf}, 32'h0);
    scs_down();
    check("mr_quiet", {27'd0, line_done, frame_done, clear_req, err_trunc, err_ovf}, 32'h0);
    clear_mon();
    exp_word = 16'h0F0F;
    scs_up();
    send_bits(32'h80, 8);
    send_line(10'h0AA, 16'h0F0F);
    scs_down();
    check("mr_words", n_xfer, 32'd21);
    check("mr_bad", n_bad, 32'd0);
    check("mr_addr2", {22'd0, line_addr}, 32'h0AA);
    check("mr_frame", n_frame, 32'd1);
    check("mr_errs", {30'd0, err_trunc, err_ovf}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_spi_rx.md
LCD_SPI_RX -- requirements
Module: lcd_spi_rx

Interface
Parameters:
REQ-001 The block SHALL have parameter LINE_BITS, default 336: pixel data bits per line; SHALL be a multiple of DATA_W.
REQ-002 The block SHALL have parameter ADDR_W, default 10: width of the line address field.
REQ-003 The block SHALL have parameter DATA_W, default 16: width of the output data word.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port clk12, input, 1: the single clock. All logic SHALL be clocked on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-006 The block SHALL have port lcd_sclk, input, 1: serial clock, asynchronous to clk12.
REQ-007 The block SHALL have port lcd_si, input, 1: serial data, asynchronous to clk12.
REQ-008 The block SHALL have port lcd_scs, input, 1: chip select, active high, asynchronous to clk12.
REQ-009 The block SHALL have port line_addr, output, ADDR_W: address of the line currently being received.
REQ-010 The block SHALL have port data, output, DATA_W: received pixel word.
REQ-011 The block SHALL have port data_valid, output, 1: data holds a word.
REQ-012 The block SHALL have port data_ready, input, 1: consumer accepts the word.
REQ-013 The block SHALL have port line_done, output, 1: one-cycle pulse at the end of each line's dummy field.
REQ-014 The block SHALL have port frame_done, output, 1: one-cycle pulse on clean scs deassert.
REQ-015 The block SHALL have port clear_req, output, 1: one-cycle pulse when a clear-all command is received.
REQ-016 The block SHALL have port err_trunc, output, 1: sticky flag; a frame ended mid-field.
REQ-017 The block SHALL have port err_ovf, output, 1: sticky flag; a word was dropped.

Function
REQ-018 lcd_sclk, lcd_si and lcd_scs SHALL each pass through a 2-flop synchronizer.
REQ-019 A bit SHALL be sampled from synchronized lcd_si on each synchronized lcd_sclk rising edge while synchronized lcd_scs is high.
REQ-020 All fields SHALL be received MSB-first.
REQ-021 The FSM SHALL have states IDLE, MODE, ADDR, DATA, DUMMY and SKIP.
REQ-022 IDLE SHALL go to MODE on the synchronized scs rising edge, clearing the bit counter.
REQ-023 MODE SHALL collect 8 bits, then dispatch on the mode byte:
- mode[5]=1: pulse clear_req and go to SKIP (clear has priority over write).
- otherwise mode[7]=1: go to ADDR.
- otherwise: go to SKIP.
REQ-024 ADDR SHALL collect ADDR_W bits into line_addr, then go to DATA.
REQ-025 DATA SHALL collect LINE_BITS bits. Each completed DATA_W-bit word SHALL be loaded into the output register with data_valid=1 on the cycle after its last bit's sclk edge is detected (latency 1 clk12).
REQ-026 DATA SHALL go to DUMMY after the last bit.
REQ-027 DUMMY SHALL collect 8 bits (values ignored), pulse line_done, then go to ADDR; multi-line writes repeat ADDR/DATA/DUMMY.
REQ-028 SKIP SHALL ignore all bits until scs falls.
REQ-029 Output handshake: the word SHALL transfer on data_valid & data_ready.
- data and data_valid SHALL hold until transfer.
- A word completing while data_valid=1 and no transfer occurs that cycle SHALL be dropped and SHALL set err_ovf.
- A simultaneous transfer and new word SHALL load the new word with data_valid remaining 1.
REQ-030 A synchronized scs falling edge SHALL return the FSM to IDLE from any state.
- From ADDR with 0 bits collected, from SKIP, or from MODE before any bit: frame_done SHALL pulse.
- From MODE after at least 1 bit, from ADDR after at least 1 bit, or from DATA or DUMMY: err_trunc SHALL set, and no frame_done.
- A pending data_valid word SHALL remain until accepted.
REQ-031 sclk edges seen while scs is low SHALL be ignored.
REQ-032 line_addr SHALL hold its value until the next ADDR field completes.

Reset
REQ-033 When reset_n=0 at a clk12 edge:
- FSM SHALL go to IDLE; counters and synchronizers SHALL be cleared to 0.
- data SHALL be 0, data_valid 0, line_addr 0, line_done 0, frame_done 0, clear_req 0, err_trunc 0, err_ovf 0.
REQ-034 A reset mid-frame SHALL abandon the frame without raising any flag. The block SHALL stay in IDLE until a fresh scs rising edge is detected after reset_n=1.
REQ-035 Sticky flags SHALL clear only on reset.

Configuration
REQ-036 With LCD_SPI_RX_LINECOUNT_EN defined:
- The block SHALL have an extra output port line_count, 16 bits.
- line_count SHALL increment on each line_done, wrap 0xFFFF to 0x0000, and reset to 0.
REQ-037 Without LCD_SPI_RX_LINECOUNT_EN, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-038 Single line: mode 0x80, addr 0x005, 336 bits of pattern 0xA5A5, 8 dummy bits, scs low, data_ready=1 -> 21 words of 0xA5A5, line_addr=0x005, one line_done, one frame_done, no errors.
REQ-039 Two lines: addr 0x000 then addr 0x217 -> 42 words, two line_done pulses, final line_addr=0x217; with LCD_SPI_RX_LINECOUNT_EN, line_count=2.
REQ-040 Clear command: mode 0x20, then 8 zero bits, scs low -> clear_req pulses once, no data_valid, frame_done pulses once.
REQ-041 Backpressure: data_ready held 0 for the whole line -> first word 0x1234 held, err_ovf=1, the remaining 20 words are dropped.
REQ-042 Truncation: scs drops after 100 data bits -> 6 words output, err_trunc=1, no frame_done, FSM in IDLE.
REQ-043 Reset mid-DATA: reset_n=0 for 1 cycle, then a valid frame is sent -> all outputs 0 after reset, and the next frame is received correctly.
